// File: rtl/io_port_ctrl_pkg.sv
// io_port_pkg: shared definitions for the io_port_ctrl register block.
//   ADDR_W          width of the CPU register-select bus
//   IO_ADDR_*       register map addresses (SW .. EVTF, plus the reserved slot)
package io_port_pkg;

   localparam int ADDR_W = 3;

   localparam logic [ADDR_W-1:0] IO_ADDR_SW   = 3'd0;  // switch levels, ro
   localparam logic [ADDR_W-1:0] IO_ADDR_BTN  = 3'd1;  // debounced button levels, ro
   localparam logic [ADDR_W-1:0] IO_ADDR_EVT  = 3'd2;  // rising-edge events, rw1c
   localparam logic [ADDR_W-1:0] IO_ADDR_LEDR = 3'd3;  // red LED bank, rw
   localparam logic [ADDR_W-1:0] IO_ADDR_LEDG = 3'd4;  // green LED bank, rw
   localparam logic [ADDR_W-1:0] IO_ADDR_MASK = 3'd5;  // per-channel irq mask, rw
   localparam logic [ADDR_W-1:0] IO_ADDR_EVTF = 3'd6;  // falling-edge events, rw1c (optional)
   localparam logic [ADDR_W-1:0] IO_ADDR_RSVD = 3'd7;  // reads 0, writes ignored

endpackage

// File: rtl/io_port_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser followed by a stability-counter debouncer
// for one raw button input, with single-cycle edge pulses on the debounced level.
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   din    in   raw asynchronous button level
//   dout   out  debounced level
//   rise   out  one-cycle pulse in the cycle after dout goes 0->1
//   fall   out  one-cycle pulse in the cycle after dout goes 1->0
// The synchronised level must disagree with dout for DEB_CYCLES consecutive
// edges before dout follows it; raw-to-dout latency is 2 + DEB_CYCLES edges.
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_deb;
   logic             r_deb_d1;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_deb    <= 1'b0;
         r_deb_d1 <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1  <= din;
         r_sync2  <= r_sync1;
         r_deb_d1 <= r_deb;
         if (r_sync2 != r_deb) begin
            if (r_cnt == CNT_LAST) begin
               r_deb <= r_sync2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            // any return to agreement restarts the stability window
            r_cnt <= '0;
         end
      end
   end

   assign dout = r_deb;
   assign rise = r_deb & ~r_deb_d1;
   assign fall = ~r_deb & r_deb_d1;

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O block between the CPU and board switches,
// buttons and LEDs. Buttons are synchronised and debounced, debounced rising
// edges latch into a rw1c event register gated by a mask onto irq.
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   addr      in   register select (see io_port_pkg)
//   we / re   in   write / read strobes, sampled on rising clk
//   wdata     in   write data
//   rdata     out  registered read data, held between reads
//   switches  in   raw switch levels (2-flop synchronised, no debounce)
//   buttons   in   raw active-high buttons
//   led_r     out  red LED register
//   led_g     out  green LED register
//   irq       out  registered |(events & mask)
// Build option: IO_PORT_CTRL_FALL_EDGE_EN adds a falling-edge event register
// at IO_ADDR_EVTF that also feeds irq; without it that address reads 0.
module io_port_ctrl
   import io_port_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int N_BTN      = 4,
   parameter int N_SW       = 10,
   parameter int N_LEDR     = 10,
   parameter int N_LEDG     = 8,
   parameter int DEB_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic              re,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   input  logic [N_SW-1:0]   switches,
   input  logic [N_BTN-1:0]  buttons,
   output logic [N_LEDR-1:0] led_r,
   output logic [N_LEDG-1:0] led_g,
   output logic              irq
);

   logic [N_SW-1:0]   r_sw_s1;
   logic [N_SW-1:0]   r_sw_s2;
   logic [N_LEDR-1:0] r_led_r;
   logic [N_LEDG-1:0] r_led_g;
   logic [N_BTN-1:0]  r_mask;
   logic [N_BTN-1:0]  r_evt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_irq;

   logic [N_BTN-1:0]  w_deb;
   logic [N_BTN-1:0]  w_rise;
   logic [N_BTN-1:0]  w_fall;
   logic [N_BTN-1:0]  w_evt_clr;
   logic [N_BTN-1:0]  w_evt_pend;
   logic [DATA_W-1:0] w_rd;
   logic              w_unused_wdata;

   // upper wdata bits beyond the widest register are intentionally dropped
   assign w_unused_wdata = ^wdata;

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk   (clk),
         .reset (reset),
         .din   (buttons[g]),
         .dout  (w_deb[g]),
         .rise  (w_rise[g]),
         .fall  (w_fall[g])
      );
   end

   assign w_evt_clr = (we && (addr == IO_ADDR_EVT)) ? wdata[N_BTN-1:0] : '0;

`ifdef IO_PORT_CTRL_FALL_EDGE_EN
   logic [N_BTN-1:0] r_evt_fall;
   logic [N_BTN-1:0] w_evtf_clr;

   assign w_evtf_clr = (we && (addr == IO_ADDR_EVTF)) ? wdata[N_BTN-1:0] : '0;

   // new edge ORed in after the clear so a colliding set wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_evt_fall <= '0;
      else        r_evt_fall <= (r_evt_fall & ~w_evtf_clr) | w_fall;
   end

   assign w_evt_pend = r_evt | r_evt_fall;
`else
   logic w_unused_fall;
   assign w_unused_fall = ^w_fall;
   assign w_evt_pend    = r_evt;
`endif

   always_comb begin
      w_rd = '0;
      case (addr)
         IO_ADDR_SW:   w_rd[N_SW-1:0]   = r_sw_s2;
         IO_ADDR_BTN:  w_rd[N_BTN-1:0]  = w_deb;
         IO_ADDR_EVT:  w_rd[N_BTN-1:0]  = r_evt;
         IO_ADDR_LEDR: w_rd[N_LEDR-1:0] = r_led_r;
         IO_ADDR_LEDG: w_rd[N_LEDG-1:0] = r_led_g;
         IO_ADDR_MASK: w_rd[N_BTN-1:0]  = r_mask;
`ifdef IO_PORT_CTRL_FALL_EDGE_EN
         IO_ADDR_EVTF: w_rd[N_BTN-1:0]  = r_evt_fall;
`endif
         default:      w_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sw_s1 <= '0;
         r_sw_s2 <= '0;
         r_led_r <= '0;
         r_led_g <= '0;
         r_mask  <= '0;
         r_evt   <= '0;
         r_rdata <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_sw_s1 <= switches;
         r_sw_s2 <= r_sw_s1;
         r_evt   <= (r_evt & ~w_evt_clr) | w_rise;
         r_irq   <= |(w_evt_pend & r_mask);
         // mux sees pre-write contents, so a same-cycle read returns the old value
         if (re) r_rdata <= w_rd;
         if (we) begin
            case (addr)
               IO_ADDR_LEDR: r_led_r <= wdata[N_LEDR-1:0];
               IO_ADDR_LEDG: r_led_g <= wdata[N_LEDG-1:0];
               IO_ADDR_MASK: r_mask  <= wdata[N_BTN-1:0];
               default: ;
            endcase
         end
      end
   end

   assign rdata = r_rdata;
   assign led_r = r_led_r;
   assign led_g = r_led_g;
   assign irq   = r_irq;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed testbench for io_port_ctrl with default parameters
// (DATA_W=16, N_BTN=4, N_SW=10, N_LEDR=10, N_LEDG=8, DEB_CYCLES=16).
// Honours IO_PORT_CTRL_FALL_EDGE_EN for the falling-edge register checks.
module tb_io_port_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  addr;
   logic        we;
   logic        re;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic [9:0]  switches;
   logic [3:0]  buttons;
   logic [9:0]  led_r;
   logic [7:0]  led_g;
   logic        irq;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   io_port_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .we       (we),
      .re       (re),
      .wdata    (wdata),
      .rdata    (rdata),
      .switches (switches),
      .buttons  (buttons),
      .led_r    (led_r),
      .led_g    (led_g),
      .irq      (irq)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // one bus cycle: strobes set at negedge, sampled at next posedge
   task automatic bus(input logic [2:0] a, input logic w, input logic r, input logic [15:0] d);
      @(negedge clk);
      addr = a; we = w; re = r; wdata = d;
      @(posedge clk);
      #1;
      we = 1'b0; re = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus(a, 1'b1, 1'b0, d);
   endtask

   task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
      bus(a, 1'b0, 1'b1, 16'h0);
      check(tag, rdata, exp);
   endtask

   task automatic btn(input int i, input logic v);
      @(negedge clk);
      buttons[i] = v;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
      switches = '0; buttons = '0;
      #1;
      check("rst_rdata", rdata, 16'h0);
      check("rst_led_r", {6'h0, led_r}, 16'h0);
      check("rst_irq",   {15'h0, irq}, 16'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      cycles(2);
      check("post_rst_led_g", {8'h0, led_g}, 16'h0);

      // register map, truncation, switch sync latency
      wr(3'd3, 16'hFFFF);
      check("ledr_port", {6'h0, led_r}, 16'h03FF);
      rd(3'd3, "ledr_read", 16'h03FF);
      wr(3'd4, 16'h01A5);
      check("ledg_port", {8'h0, led_g}, 16'h00A5);
      rd(3'd4, "ledg_read", 16'h00A5);
      @(negedge clk);
      switches = 10'h155;
      @(posedge clk);
      rd(3'd0, "sw_before_sync", 16'h0000);
      rd(3'd0, "sw_after_sync", 16'h0155);
      wr(3'd0, 16'h0000);
      rd(3'd0, "sw_ro", 16'h0155);
      wr(3'd7, 16'hFFFF);
      rd(3'd7, "addr7", 16'h0000);
      bus(3'd3, 1'b1, 1'b1, 16'h0012);
      check("rw_same_pre", rdata, 16'h03FF);
      check("rw_same_led", {6'h0, led_r}, 16'h0012);
      cycles(3);
      check("rdata_hold", rdata, 16'h03FF);
      rd(3'd3, "ledr_new", 16'h0012);

      // debounce: short glitch rejected
      btn(0, 1'b1);
      repeat (10) @(posedge clk);
      btn(0, 1'b0);
      cycles(25);
      rd(3'd1, "glitch_btn", 16'h0000);
      rd(3'd2, "glitch_evt", 16'h0000);

      // debounce: held press, deb changes at edge 18, evt at edge 19
      btn(0, 1'b1);
      repeat (17) @(posedge clk);
      rd(3'd1, "deb_edge18", 16'h0000);
      rd(3'd1, "deb_edge19", 16'h0001);
      rd(3'd2, "evt_set",    16'h0001);
      check("irq_masked", {15'h0, irq}, 16'h0);
      wr(3'd2, 16'h0001);
      rd(3'd2, "evt_clr", 16'h0000);
      btn(0, 1'b0);
      cycles(25);

      // irq path with mask
      wr(3'd5, 16'h0002);
      btn(1, 1'b1);
      cycles(22);
      check("irq_set", {15'h0, irq}, 16'h1);
      wr(3'd2, 16'h0002);
      check("irq_lag", {15'h0, irq}, 16'h1);
      cycles(1);
      check("irq_clr", {15'h0, irq}, 16'h0);
      rd(3'd2, "evt1_clr", 16'h0000);
      btn(1, 1'b0);
      cycles(25);

      // clear collides with new rising edge: set wins
      btn(0, 1'b1);
      repeat (18) @(posedge clk);
      wr(3'd2, 16'h0001);
      rd(3'd2, "collide_evt", 16'h0001);
      check("collide_irq_masked", {15'h0, irq}, 16'h0);
      wr(3'd2, 16'h0001);
      rd(3'd2, "collide_clr", 16'h0000);
      btn(0, 1'b0);
      cycles(25);

      // falling-edge register / addr 6
      wr(3'd2, 16'h000F);
      wr(3'd6, 16'h000F);
      rd(3'd6, "evtf_cleared", 16'h0000);
      btn(2, 1'b1);
      cycles(22);
      btn(2, 1'b0);
      cycles(22);
      rd(3'd2, "evt_btn2", 16'h0004);
`ifdef IO_PORT_CTRL_FALL_EDGE_EN
      rd(3'd6, "evtf_btn2", 16'h0004);
`else
      rd(3'd6, "addr6_zero", 16'h0000);
`endif
      check("irq_mask_btn2", {15'h0, irq}, 16'h0);

      // async reset mid-operation
      wr(3'd3, 16'h03FF);
      wr(3'd5, 16'h000F);
      btn(0, 1'b1);
      cycles(22);
      check("pre_rst_irq", {15'h0, irq}, 16'h1);
      rd(3'd3, "pre_rst_ledr", 16'h03FF);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_rdata", rdata, 16'h0);
      check("mid_rst_led_r", {6'h0, led_r}, 16'h0);
      check("mid_rst_led_g", {8'h0, led_g}, 16'h0);
      check("mid_rst_irq",   {15'h0, irq}, 16'h0);
      buttons = '0;
      @(negedge clk);
      reset = 1'b1;
      rd(3'd2, "post_rst_evt",  16'h0000);
      rd(3'd5, "post_rst_mask", 16'h0000);
      rd(3'd3, "post_rst_ledr", 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
